// File: rtl/operand_sel.sv
// Operand resolution and hold stage between the bypass network and EX.
// Optional write-back collision bypass is enabled by defining OPSEL_WB_BYPASS_EN.
module operand_sel #(
    parameter int STALL_W = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [STALL_W-1:0] stall,
    input  logic               id_valid,
    input  logic [4:0]         rs_rf_raddr,
    input  logic [4:0]         rt_rf_raddr,
    input  logic               sel_rs_forward_r,
    input  logic               sel_rt_forward_r,
    input  logic [31:0]        rs_forward_data_r,
    input  logic [31:0]        rt_forward_data_r,
    input  logic [31:0]        rs_rf_rdata,
    input  logic [31:0]        rt_rf_rdata,
    input  logic               wb_we,
    input  logic [4:0]         wb_waddr,
    input  logic [31:0]        wb_wdata,
    output logic               ex_valid,
    output logic [31:0]        ex_rs_data,
    output logic [31:0]        ex_rt_data,
    output logic [4:0]         ex_rs_addr,
    output logic [4:0]         ex_rt_addr
);

    localparam int  STALL_IDEX = 3;
    localparam int  STALL_EX   = 4;
    localparam logic STOP      = 1'b1;

    logic        r_ex_valid;
    logic [4:0]  r_rs_addr;
    logic [4:0]  r_rt_addr;
    logic        r_hold_flag;
    logic [31:0] r_hold_rs;
    logic [31:0] r_hold_rt;

    logic        w_idex_stop;
    logic        w_ex_stop;
    logic [31:0] w_live_rs;
    logic [31:0] w_live_rt;

    assign w_idex_stop = (stall[STALL_IDEX] == STOP);
    assign w_ex_stop   = (stall[STALL_EX] == STOP);

    // Only the ID/EX and EX boundary bits matter to this stage.
    logic w_unused_stall;
    assign w_unused_stall = ^{stall[STALL_W-1:STALL_EX+1], stall[STALL_IDEX-1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_valid <= 1'b0;
            r_rs_addr  <= 5'd0;
            r_rt_addr  <= 5'd0;
        end else if (flush) begin
            r_ex_valid <= 1'b0;
            r_rs_addr  <= 5'd0;
            r_rt_addr  <= 5'd0;
        end else if (w_idex_stop && !w_ex_stop) begin
            // ID held but EX moving on: insert a bubble
            r_ex_valid <= 1'b0;
            r_rs_addr  <= 5'd0;
            r_rt_addr  <= 5'd0;
        end else if (!w_idex_stop) begin
            r_ex_valid <= id_valid;
            r_rs_addr  <= rs_rf_raddr;
            r_rt_addr  <= rt_rf_raddr;
        end
    end

`ifdef OPSEL_WB_BYPASS_EN
    // Read-first register file: a write landing this cycle is not yet in rf_rdata.
    logic w_wb_hit_rs;
    logic w_wb_hit_rt;
    assign w_wb_hit_rs = wb_we && (wb_waddr == r_rs_addr) && (r_rs_addr != 5'd0) && !sel_rs_forward_r;
    assign w_wb_hit_rt = wb_we && (wb_waddr == r_rt_addr) && (r_rt_addr != 5'd0) && !sel_rt_forward_r;

    always_comb begin
        w_live_rs = sel_rs_forward_r ? rs_forward_data_r : rs_rf_rdata;
        w_live_rt = sel_rt_forward_r ? rt_forward_data_r : rt_rf_rdata;
        if (w_wb_hit_rs) w_live_rs = wb_wdata;
        if (w_wb_hit_rt) w_live_rt = wb_wdata;
    end
`else
    logic w_unused_wb;
    assign w_unused_wb = ^{wb_we, wb_waddr, wb_wdata};

    always_comb begin
        w_live_rs = sel_rs_forward_r ? rs_forward_data_r : rs_rf_rdata;
        w_live_rt = sel_rt_forward_r ? rt_forward_data_r : rt_rf_rdata;
    end
`endif

    // The rf read port drifts during a stall, so the first-cycle operands are frozen here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_flag <= 1'b0;
            r_hold_rs   <= 32'd0;
            r_hold_rt   <= 32'd0;
        end else if (flush) begin
            r_hold_flag <= 1'b0;
            r_hold_rs   <= 32'd0;
            r_hold_rt   <= 32'd0;
        end else if (w_ex_stop) begin
            if (r_ex_valid && !r_hold_flag) begin
                r_hold_flag <= 1'b1;
                r_hold_rs   <= w_live_rs;
                r_hold_rt   <= w_live_rt;
            end
        end else begin
            r_hold_flag <= 1'b0;
        end
    end

    always_comb begin
        ex_valid   = r_ex_valid;
        ex_rs_addr = r_rs_addr;
        ex_rt_addr = r_rt_addr;
        ex_rs_data = 32'd0;
        ex_rt_data = 32'd0;
        if (r_ex_valid) begin
            ex_rs_data = r_hold_flag ? r_hold_rs : w_live_rs;
            ex_rt_data = r_hold_flag ? r_hold_rt : w_live_rt;
        end
    end

endmodule

// File: tb/tb_operand_sel.sv
// Directed bench for operand_sel: vector table for operand resolution plus
// hand sequences for stall hold, bubble, flush and asynchronous reset.
module tb_operand_sel;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [8:0]  stall;
    logic        id_valid;
    logic [4:0]  rs_rf_raddr;
    logic [4:0]  rt_rf_raddr;
    logic        sel_rs_forward_r;
    logic        sel_rt_forward_r;
    logic [31:0] rs_forward_data_r;
    logic [31:0] rt_forward_data_r;
    logic [31:0] rs_rf_rdata;
    logic [31:0] rt_rf_rdata;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        ex_valid;
    logic [31:0] ex_rs_data;
    logic [31:0] ex_rt_data;
    logic [4:0]  ex_rs_addr;
    logic [4:0]  ex_rt_addr;

    int total;
    int bad;

    localparam logic [8:0] ST_NONE = 9'b0_0000_0000;
    localparam logic [8:0] ST_EX   = 9'b0_0001_1000;
    localparam logic [8:0] ST_IDEX = 9'b0_0000_1000;

    operand_sel #(.STALL_W(9)) dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .stall             (stall),
        .id_valid          (id_valid),
        .rs_rf_raddr       (rs_rf_raddr),
        .rt_rf_raddr       (rt_rf_raddr),
        .sel_rs_forward_r  (sel_rs_forward_r),
        .sel_rt_forward_r  (sel_rt_forward_r),
        .rs_forward_data_r (rs_forward_data_r),
        .rt_forward_data_r (rt_forward_data_r),
        .rs_rf_rdata       (rs_rf_rdata),
        .rt_rf_rdata       (rt_rf_rdata),
        .wb_we             (wb_we),
        .wb_waddr          (wb_waddr),
        .wb_wdata          (wb_wdata),
        .ex_valid          (ex_valid),
        .ex_rs_data        (ex_rs_data),
        .ex_rt_data        (ex_rt_data),
        .ex_rs_addr        (ex_rs_addr),
        .ex_rt_addr        (ex_rt_addr)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rs_a;
        logic [4:0]  rt_a;
        logic        sel_rs;
        logic        sel_rt;
        logic [31:0] fwd_rs;
        logic [31:0] fwd_rt;
        logic [31:0] rf_rs;
        logic [31:0] rf_rt;
        logic        wb_en;
        logic [4:0]  wb_a;
        logic [31:0] wb_d;
        logic [31:0] exp_rs;
        logic [31:0] exp_rt;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs_a, input logic [4:0] rt_a);
        id_valid    = v;
        rs_rf_raddr = rs_a;
        rt_rf_raddr = rt_a;
    endtask

    task automatic drive_data(input logic s_rs, input logic s_rt, input logic [31:0] f_rs,
                              input logic [31:0] f_rt, input logic [31:0] d_rs, input logic [31:0] d_rt);
        sel_rs_forward_r  = s_rs;
        sel_rt_forward_r  = s_rt;
        rs_forward_data_r = f_rs;
        rt_forward_data_r = f_rt;
        rs_rf_rdata       = d_rs;
        rt_rf_rdata       = d_rt;
    endtask

    initial begin
        logic [31:0] wb_exp_rs4;
        logic [31:0] wb_exp_rt5;
        total = 0;
        bad   = 0;
`ifdef OPSEL_WB_BYPASS_EN
        wb_exp_rs4 = 32'h99;
        wb_exp_rt5 = 32'h99;
`else
        wb_exp_rs4 = 32'h1;
        wb_exp_rt5 = 32'h3;
`endif
        //          rs  rt  srs  srt  fwd_rs        fwd_rt        rf_rs         rf_rt         wb  wba  wbd     exp_rs        exp_rt
        vecs[0] = '{5,  6,  1,   0,   32'h1234,     32'h5555,     32'hDEAD,     32'hCAFE,     0,  0,   0,      32'h1234,     32'hCAFE};
        vecs[1] = '{5,  6,  0,   1,   32'h1234,     32'h0F0F0F0F, 32'hDEAD,     32'h77,       0,  0,   0,      32'hDEAD,     32'h0F0F0F0F};
        vecs[2] = '{1,  31, 1,   1,   32'hFFFFFFFF, 32'h80000000, 32'h1,        32'h2,        0,  0,   0,      32'hFFFFFFFF, 32'h80000000};
        vecs[3] = '{12, 13, 0,   0,   32'h11,       32'h22,       32'hA5A5A5A5, 32'h5A5A5A5A, 0,  0,   0,      32'hA5A5A5A5, 32'h5A5A5A5A};
        vecs[4] = '{7,  8,  0,   0,   32'h0,        32'h0,        32'h1,        32'h22,       1,  7,   32'h99, wb_exp_rs4,   32'h22};
        vecs[5] = '{9,  9,  1,   0,   32'h44,       32'h0,        32'h3,        32'h3,        1,  9,   32'h99, 32'h44,       wb_exp_rt5};
        vecs[6] = '{0,  0,  0,   0,   32'h0,        32'h0,        32'h0,        32'h0,        1,  0,   32'h99, 32'h0,        32'h0};

        rst   = 1'b1;
        flush = 1'b0;
        stall = ST_NONE;
        wb_we = 1'b0;
        wb_waddr = 5'd0;
        wb_wdata = 32'd0;
        drive_id(1'b0, 5'd0, 5'd0);
        drive_data(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        #1;
        check("reset ex_valid", {31'd0, ex_valid}, 32'd0);
        check("reset ex_rs_data", ex_rs_data, 32'd0);
        check("reset ex_rt_data", ex_rt_data, 32'd0);
        check("reset ex_rs_addr", {27'd0, ex_rs_addr}, 32'd0);
        check("reset ex_rt_addr", {27'd0, ex_rt_addr}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        next_cyc();
        drive_data(1'b1, 1'b1, 32'h5, 32'h6, 32'h7, 32'h8);
        settle();
        check("idle after reset ex_valid", {31'd0, ex_valid}, 32'd0);
        check("idle after reset ex_rs_data", ex_rs_data, 32'd0);

        // table: ID cycle, then operand cycle
        for (int i = 0; i < 7; i++) begin
            next_cyc();
            drive_id(1'b1, vecs[i].rs_a, vecs[i].rt_a);
            wb_we = 1'b0;
            settle();
            if (i > 0) begin
                check("gap ex_valid", {31'd0, ex_valid}, 32'd0);
                check("gap ex_rs_data", ex_rs_data, 32'd0);
            end
            next_cyc();
            drive_id(1'b0, 5'd0, 5'd0);
            drive_data(vecs[i].sel_rs, vecs[i].sel_rt, vecs[i].fwd_rs, vecs[i].fwd_rt,
                       vecs[i].rf_rs, vecs[i].rf_rt);
            wb_we    = vecs[i].wb_en;
            wb_waddr = vecs[i].wb_a;
            wb_wdata = vecs[i].wb_d;
            settle();
            check("vec ex_valid", {31'd0, ex_valid}, 32'd1);
            check("vec ex_rs_addr", {27'd0, ex_rs_addr}, {27'd0, vecs[i].rs_a});
            check("vec ex_rt_addr", {27'd0, ex_rt_addr}, {27'd0, vecs[i].rt_a});
            check("vec ex_rs_data", ex_rs_data, vecs[i].exp_rs);
            check("vec ex_rt_data", ex_rt_data, vecs[i].exp_rt);
        end
        wb_we = 1'b0;

        // stall hold: 3 stall cycles, first release cycle still shows the held value
        next_cyc();
        drive_id(1'b1, 5'd2, 5'd3);
        next_cyc();
        drive_id(1'b0, 5'd0, 5'd0);
        drive_data(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'hAAAA);
        stall = ST_EX;
        settle();
        check("stall c1 ex_rt_data", ex_rt_data, 32'hAAAA);
        next_cyc();
        rt_rf_rdata = 32'hBBBB;
        settle();
        check("stall c2 ex_rt_data", ex_rt_data, 32'hAAAA);
        check("stall c2 hold_flag", {31'd0, dut.r_hold_flag}, 32'd1);
        next_cyc();
        settle();
        check("stall c3 ex_rt_data", ex_rt_data, 32'hAAAA);
        next_cyc();
        stall = ST_NONE;
        drive_id(1'b1, 5'd2, 5'd3);
        settle();
        check("release ex_rt_data", ex_rt_data, 32'hAAAA);
        check("release ex_valid", {31'd0, ex_valid}, 32'd1);
        // second stall right after a single NoStop cycle captures afresh
        next_cyc();
        drive_id(1'b0, 5'd0, 5'd0);
        stall = ST_EX;
        settle();
        check("restall hold_flag", {31'd0, dut.r_hold_flag}, 32'd0);
        check("restall c1 ex_rt_data", ex_rt_data, 32'hBBBB);
        next_cyc();
        rt_rf_rdata = 32'hCCCC;
        settle();
        check("restall c2 ex_rt_data", ex_rt_data, 32'hBBBB);
        next_cyc();
        stall = ST_NONE;
        settle();
        check("restall release ex_rt_data", ex_rt_data, 32'hBBBB);
        next_cyc();
        settle();
        check("after release hold_flag", {31'd0, dut.r_hold_flag}, 32'd0);
        check("after release ex_valid", {31'd0, ex_valid}, 32'd0);

        // bubble: ID held, EX free
        next_cyc();
        drive_id(1'b1, 5'd5, 5'd6);
        next_cyc();
        drive_id(1'b0, 5'd0, 5'd0);
        drive_data(1'b0, 1'b0, 32'h0, 32'h0, 32'h1357, 32'h2468);
        stall = ST_IDEX;
        settle();
        check("pre-bubble ex_rs_data", ex_rs_data, 32'h1357);
        next_cyc();
        stall = ST_NONE;
        settle();
        check("bubble ex_valid", {31'd0, ex_valid}, 32'd0);
        check("bubble ex_rs_addr", {27'd0, ex_rs_addr}, 32'd0);
        check("bubble ex_rs_data", ex_rs_data, 32'd0);
        check("bubble ex_rt_data", ex_rt_data, 32'd0);

        // flush while holding, with the stall still asserted
        next_cyc();
        drive_id(1'b1, 5'd4, 5'd4);
        next_cyc();
        drive_id(1'b0, 5'd0, 5'd0);
        drive_data(1'b1, 1'b0, 32'h4242, 32'h0, 32'h0, 32'h5151);
        stall = ST_EX;
        next_cyc();
        settle();
        check("flush pre hold_flag", {31'd0, dut.r_hold_flag}, 32'd1);
        check("flush pre ex_rs_data", ex_rs_data, 32'h4242);
        next_cyc();
        flush = 1'b1;
        next_cyc();
        flush = 1'b0;
        settle();
        check("flush ex_valid", {31'd0, ex_valid}, 32'd0);
        check("flush hold_flag", {31'd0, dut.r_hold_flag}, 32'd0);
        check("flush hold_rs", dut.r_hold_rs, 32'd0);
        check("flush ex_rs_data", ex_rs_data, 32'd0);
        check("flush ex_rt_data", ex_rt_data, 32'd0);
        stall = ST_NONE;

        // asynchronous reset in the middle of a stall
        next_cyc();
        drive_id(1'b1, 5'd10, 5'd11);
        next_cyc();
        drive_id(1'b0, 5'd0, 5'd0);
        drive_data(1'b0, 1'b0, 32'h0, 32'h0, 32'h1111, 32'h2222);
        stall = ST_EX;
        next_cyc();
        settle();
        check("pre-reset ex_rs_data", ex_rs_data, 32'h1111);
        check("pre-reset hold_flag", {31'd0, dut.r_hold_flag}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("async reset ex_valid", {31'd0, ex_valid}, 32'd0);
        check("async reset ex_rs_data", ex_rs_data, 32'd0);
        check("async reset ex_rt_data", ex_rt_data, 32'd0);
        check("async reset hold_flag", {31'd0, dut.r_hold_flag}, 32'd0);
        #1;
        rst = 1'b0;
        stall = ST_NONE;
        next_cyc();
        settle();
        check("post-reset ex_valid", {31'd0, ex_valid}, 32'd0);
        check("post-reset ex_rs_data", ex_rs_data, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/operand_sel.md
# operand_sel

Operand resolution and hold stage between the bypass network and EX. Each cycle it merges the registered forward select/data from the bypass unit with the synchronous-read register-file output. It also registers the ID→EX valid bit and source addresses. It freezes the resolved rs/rt operands while EX is stalled, because the register-file output port is not stable across a stall.

## Interface
Parameters:
- STALL_W, 9, width of the pipeline stall bus; bit 3 = ID/EX boundary, bit 4 = EX.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  reset; asynchronous, active-high.
- flush  in  1  exception/ERET flush; kills the EX-stage operand slot.
- stall  in  STALL_W  stall bus; Stop = 1, NoStop = 0.
- id_valid  in  1  instruction present in ID this cycle.
- rs_rf_raddr, rt_rf_raddr  in  5 each  ID source addresses, same cycle as id_valid.
- sel_rs_forward_r, sel_rt_forward_r  in  1 each  registered forward-select flags from the bypass unit, valid the cycle after ID.
- rs_forward_data_r, rt_forward_data_r  in  32 each  registered forward data from the bypass unit.
- rs_rf_rdata, rt_rf_rdata  in  32 each  synchronous register-file read data, valid the cycle after ID.
- wb_we  in  1  write-back enable; used only with OPSEL_WB_BYPASS_EN.
- wb_waddr  in  5  write-back address; used only with OPSEL_WB_BYPASS_EN.
- wb_wdata  in  32  write-back data; used only with OPSEL_WB_BYPASS_EN.
- ex_valid  out  1  EX slot holds a live instruction.
- ex_rs_data, ex_rt_data  out  32 each  resolved operands to EX.
- ex_rs_addr, ex_rt_addr  out  5 each  registered source addresses.

## Operation
- Slot register: holds ex_valid, ex_rs_addr and ex_rt_addr.
  - Load: when stall[3]==NoStop, load id_valid, rs_rf_raddr and rt_rf_raddr.
  - Bubble: when stall[3]==Stop && stall[4]==NoStop, clear ex_valid and both addresses to 0.
  - Otherwise hold.
  - Priority: rst > flush (clears the slot) > bubble > load > hold.
- Live operand, per source x ∈ {rs, rt}:
  - live_x = sel_x_forward_r ? x_forward_data_r : x_rf_rdata.
  - Addresses equal to 0 are already forced to 0 by the bypass unit; this block does not re-check.
- Hold registers hold_x (32 bits) and a shared hold_flag:
  - Capture: on the first cycle with stall[4]==Stop, ex_valid==1 and hold_flag==0, set hold_x ← resolved live value and hold_flag ← 1.
  - Release: hold_flag clears on the first cycle with stall[4]==NoStop.
  - Flush: clears hold_flag and both hold_x.
- Output: ex_x_data = ~ex_valid ? 0 : hold_flag ? hold_x : live_x.
- Simultaneous flush and stall: flush wins. The slot and hold state clear, and outputs are 0 the next cycle.

## Timing
- Reset values:
  - ex_valid = 0, ex_rs_addr = ex_rt_addr = 0.
  - hold_flag = 0, hold_x = 0, so ex_rs_data = ex_rt_data = 0.
- Latency: operands are valid combinationally in the cycle after ID issue, in the same cycle as the bypass registered outputs and the register-file data. There is no added cycle.
- Stall of N cycles in EX:
  - Cycle 1 drives live_x and captures it.
  - Cycles 2..N drive hold_x.
  - The first NoStop cycle still drives hold_x, then hold_flag clears at that clock edge.
- Reset asserted mid-stall: all state clears immediately (asynchronous). No captured value survives.
- Back-to-back stalls separated by one NoStop cycle: the second stall performs a fresh capture.

## Configuration
- OPSEL_WB_BYPASS_EN defined:
  - Live value additionally overridden: when wb_we && wb_waddr==ex_x_addr && ex_x_addr!=0 && ~sel_x_forward_r, live_x = wb_wdata.
  - This covers the same-cycle write/read collision on a read-first register file.
  - The override applies to the capture as well.
- Undefined:
  - wb_* ports are present but ignored.
  - The register file must be write-first.

## Test plan
- Reset: assert rst asynchronously mid-cycle -> ex_valid=0, ex_rs_data=0 and ex_rt_data=0 immediately; after release with no id_valid, outputs stay 0.
- Forward select: id_valid=1, rs addr=5; next cycle sel_rs_forward_r=1, rs_forward_data_r=0x1234, rs_rf_rdata=0xDEAD -> ex_rs_data=0x1234; with sel=0 -> 0xDEAD.
- Stall hold:
  - Stimulus: stall[4]=Stop for 3 cycles with live_rt=0xAAAA in the first cycle, then rt_rf_rdata changes to 0xBBBB.
  - Required response: ex_rt_data=0xAAAA for all 3 cycles and the first release cycle; hold_flag=0 afterwards.
- Bubble: stall[3]=Stop, stall[4]=NoStop -> next cycle ex_valid=0 and operands 0.
- Flush during hold: flush=1 while hold_flag=1 -> next cycle ex_valid=0, hold_flag=0, outputs 0.
- OPSEL_WB_BYPASS_EN:
  - Stimulus: ex_rs_addr=7, sel=0, rs_rf_rdata=0x1, wb_we=1, wb_waddr=7, wb_wdata=0x99.
  - Required response: ex_rs_data=0x99 with the macro defined, 0x1 without it.
